// File: rtl/stage_pipe_buf.sv
// stage_pipe_buf: elastic valid/ready buffer between two pipeline stages (DEPTH-entry circular FIFO, flush, occupancy); ports: i_sys_clk/i_sys_rst, i_flush, upstream i_up_valid/o_up_ready/i_up_data, downstream o_dn_valid/i_dn_ready/o_dn_data, status o_count/o_full/o_empty
module stage_pipe_buf #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH = 2,
  localparam int CNT_WIDTH = $clog2(DEPTH + 1)
) (
  input  logic                  i_sys_clk,
  input  logic                  i_sys_rst,
  input  logic                  i_flush,
  input  logic                  i_up_valid,
  output logic                  o_up_ready,
  input  logic [DATA_WIDTH-1:0] i_up_data,
  output logic                  o_dn_valid,
  input  logic                  i_dn_ready,
  output logic [DATA_WIDTH-1:0] o_dn_data,
  output logic [CNT_WIDTH-1:0]  o_count,
  output logic                  o_full,
  output logic                  o_empty
);
  localparam int PTR_WIDTH = DEPTH > 1 ? $clog2(DEPTH) : 1;
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = CNT_WIDTH'(DEPTH);
  localparam logic [PTR_WIDTH-1:0] PTR_LAST = PTR_WIDTH'(DEPTH - 1);
  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_WIDTH-1:0]  r_wr_ptr, r_rd_ptr;
  logic [CNT_WIDTH-1:0]  r_count;
  logic                  w_push, w_pop;
  // ready looks only at stored occupancy, so downstream ready never reaches upstream ready
  assign o_up_ready = !i_sys_rst && (r_count < CNT_MAX);
  assign o_dn_valid = r_count != '0;
  assign o_dn_data  = r_mem[r_rd_ptr];
  assign o_count    = r_count;
  assign o_full     = r_count == CNT_MAX;
  assign o_empty    = r_count == '0;
  assign w_push     = i_up_valid && o_up_ready;
  assign w_pop      = o_dn_valid && i_dn_ready;
  always_ff @(posedge i_sys_clk) begin
    if (i_sys_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= i_up_data;
        r_wr_ptr <= r_wr_ptr == PTR_LAST ? '0 : r_wr_ptr + 1'b1;
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr == PTR_LAST ? '0 : r_rd_ptr + 1'b1;
      if (w_push && !w_pop) r_count <= r_count + 1'b1;
      else if (w_pop && !w_push) r_count <= r_count - 1'b1;
    end
  end
endmodule
